// File: rtl/mac_table_mgmt_walker.sv
// mac_table_mgmt_walker
//   Management-side initiator for the MAC address table mgmt port. On a start
//   strobe it walks every {row, way} index (way is the inner loop), reads each
//   entry, and either streams valid entries out (DUMP) or deletes those that
//   match a filter (FLUSH_PORT / FLUSH_VLAN / FLUSH_ALL).
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, cmd_*, abort       command strobe, mode/filters (sampled on start), abort
//   busy, done, err_timeout   walk status; done pulses once at walk end
//   del_count                 entries deleted by the last walk (saturating)
//   dump_*                    valid/ready stream of dumped entries
//   mgmt_*                    single-outstanding read/delete requests to the table

module mac_table_mgmt_walker #(
   parameter int unsigned ADDR_BITS   = 11,
   parameter int unsigned WAY_BITS    = 3,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           cmd_mode,
   input  logic [4:0]           cmd_port,
   input  logic [11:0]          cmd_vlan,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 err_timeout,
   output logic [15:0]          del_count,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [ADDR_BITS-1:0] dump_addr,
   output logic [WAY_BITS-1:0]  dump_way,
   output logic [47:0]          dump_mac,
   output logic [11:0]          dump_vlan,
   output logic [4:0]           dump_port,
   output logic                 dump_gc_mark,
   output logic                 mgmt_rd_en,
   output logic                 mgmt_del_en,
   output logic [ADDR_BITS-1:0] mgmt_addr,
   output logic [WAY_BITS-1:0]  mgmt_way,
   input  logic                 mgmt_ack,
   input  logic                 mgmt_rd_valid,
   input  logic                 mgmt_rd_gc_mark,
   input  logic [47:0]          mgmt_rd_mac,
   input  logic [11:0]          mgmt_rd_vlan,
   input  logic [4:0]           mgmt_rd_port
);

   localparam int unsigned IdxW = ADDR_BITS + WAY_BITS;
   localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [IdxW-1:0] IdxMax  = '1;
   localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

   localparam logic [1:0] ModeDump      = 2'd0;
   localparam logic [1:0] ModeFlushPort = 2'd1;
   localparam logic [1:0] ModeFlushVlan = 2'd2;
   localparam logic [1:0] ModeFlushAll  = 2'd3;

   typedef enum logic [3:0] {
      StIdle, StRdReq, StRdWait, StEval, StDelReq, StDelWait, StDump, StNext, StFin
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] index_q, index_d;
   logic [1:0]      mode_q, mode_d;
   logic [4:0]      filt_port_q, filt_port_d;
   logic [11:0]     filt_vlan_q, filt_vlan_d;
   logic            abort_q, abort_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     del_count_q, del_count_d;
   logic            err_q, err_d;
   logic            ent_valid_q, ent_valid_d;
   logic            ent_gc_q, ent_gc_d;
   logic [47:0]     ent_mac_q, ent_mac_d;
   logic [11:0]     ent_vlan_q, ent_vlan_d;
   logic [4:0]      ent_port_q, ent_port_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         index_q     <= '0;
         mode_q      <= '0;
         filt_port_q <= '0;
         filt_vlan_q <= '0;
         abort_q     <= 1'b0;
         cnt_q       <= '0;
         del_count_q <= '0;
         err_q       <= 1'b0;
         ent_valid_q <= 1'b0;
         ent_gc_q    <= 1'b0;
         ent_mac_q   <= '0;
         ent_vlan_q  <= '0;
         ent_port_q  <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         mode_q      <= mode_d;
         filt_port_q <= filt_port_d;
         filt_vlan_q <= filt_vlan_d;
         abort_q     <= abort_d;
         cnt_q       <= cnt_d;
         del_count_q <= del_count_d;
         err_q       <= err_d;
         ent_valid_q <= ent_valid_d;
         ent_gc_q    <= ent_gc_d;
         ent_mac_q   <= ent_mac_d;
         ent_vlan_q  <= ent_vlan_d;
         ent_port_q  <= ent_port_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      mode_d      = mode_q;
      filt_port_d = filt_port_q;
      filt_vlan_d = filt_vlan_q;
      abort_d     = abort_q;
      cnt_d       = cnt_q;
      del_count_d = del_count_q;
      err_d       = err_q;
      ent_valid_d = ent_valid_q;
      ent_gc_d    = ent_gc_q;
      ent_mac_d   = ent_mac_q;
      ent_vlan_d  = ent_vlan_q;
      ent_port_d  = ent_port_q;

      // Abort is remembered until the walk reaches an entry boundary.
      if (abort && state_q != StIdle && state_q != StFin) begin
         abort_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               mode_d      = cmd_mode;
               filt_port_d = cmd_port;
               filt_vlan_d = cmd_vlan;
               del_count_d = '0;
               err_d       = 1'b0;
               index_d     = '0;
               abort_d     = 1'b0;
               state_d     = StRdReq;
            end
         end
         StRdReq: begin
            cnt_d   = '0;
            state_d = StRdWait;
         end
         StRdWait: begin
            if (mgmt_ack) begin
               ent_valid_d = mgmt_rd_valid;
               ent_gc_d    = mgmt_rd_gc_mark;
               ent_mac_d   = mgmt_rd_mac;
               ent_vlan_d  = mgmt_rd_vlan;
               ent_port_d  = mgmt_rd_port;
               state_d     = StEval;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StEval: begin
            if (!ent_valid_q) begin
               state_d = StNext;
            end else begin
               unique case (mode_q)
                  ModeDump:      state_d = StDump;
                  ModeFlushPort: state_d = (ent_port_q == filt_port_q) ? StDelReq : StNext;
                  ModeFlushVlan: state_d = (ent_vlan_q == filt_vlan_q) ? StDelReq : StNext;
                  ModeFlushAll:  state_d = StDelReq;
               endcase
            end
         end
         StDelReq: begin
            cnt_d   = '0;
            state_d = StDelWait;
         end
         StDelWait: begin
            if (mgmt_ack) begin
               if (del_count_q != 16'hffff) begin
                  del_count_d = del_count_q + 16'd1;
               end
               state_d = StNext;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDump: begin
            if (dump_ready) begin
               state_d = StNext;
            end
         end
         StNext: begin
            if (index_q == IdxMax || abort_q || abort) begin
               state_d = StFin;
            end else begin
               index_d = index_q + 1'b1;
               state_d = StRdReq;
            end
         end
         StFin: begin
            abort_d = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy         = (state_q != StIdle) && (state_q != StFin);
   assign done         = (state_q == StFin);
   assign err_timeout  = err_q;
   assign del_count    = del_count_q;
   assign mgmt_rd_en   = (state_q == StRdReq);
   assign mgmt_del_en  = (state_q == StDelReq);
   assign mgmt_addr    = index_q[IdxW-1:WAY_BITS];
   assign mgmt_way     = index_q[WAY_BITS-1:0];
   assign dump_valid   = (state_q == StDump);
   assign dump_addr    = index_q[IdxW-1:WAY_BITS];
   assign dump_way     = index_q[WAY_BITS-1:0];
   assign dump_mac     = ent_mac_q;
   assign dump_vlan    = ent_vlan_q;
   assign dump_port    = ent_port_q;
   assign dump_gc_mark = ent_gc_q;

endmodule
